// File: rtl/hs_rx_pkg.sv
// Shared defaults, counter width and level-width helper for the hs_rx buffer slice.
package hs_rx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W      = 32;

  // Occupancy needs one more bit than the pointers so that "full" is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [level_w(DEPTH_DEF)-1:0] level_t;
  typedef logic [CNT_W-1:0]              cnt_t;

endpackage

// File: rtl/hs_proto_chk.sv
// Sticky checker: flags an offer that is withdrawn or changed while it was stalled.
// Latency 1 cycle after the violating cycle; observes only, never applies backpressure.
module hs_proto_chk #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic              err
);

  logic              stall_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
      data_q  <= '0;
      err     <= 1'b0;
    end else begin
      stall_q <= valid & ~ready;
      data_q  <= data;
      if (stall_q && (!valid || (data != data_q))) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_rx_buffer.sv
// First-word fall-through receive buffer; push-to-visible latency 1 cycle. in_ready comes
// from registered state only. Optional rx_count statistics under HS_RX_BUFFER_STATS_EN.
module hs_rx_buffer
  import hs_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   proto_err,
  output logic [CNT_W-1:0]       rx_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              run_q;
  logic              push;
  logic              pop;

  // run_q holds in_ready low until the first edge after reset release.
  assign in_ready  = run_q && (level != FULL);
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      run_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; contents are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  hs_proto_chk #(
    .DATA_W(DATA_W)
  ) u_proto_chk (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(in_valid),
    .ready(in_ready),
    .data (in_data),
    .err  (proto_err)
  );

`ifdef HS_RX_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_count <= '0;
    end else if (push) begin
      rx_count <= rx_count + 1'b1;
    end
  end
`else
  assign rx_count = '0;
`endif

endmodule

// File: tb/tb_hs_rx_buffer.sv
// Directed, table-driven checks of hs_rx_buffer (DATA_W=8, DEPTH=4) plus hand-written corner sequences.
module tb_hs_rx_buffer;

`ifdef HS_RX_BUFFER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [2:0]  level;
  logic        proto_err;
  logic [31:0] rx_count;

  int n_chk  = 0;
  int n_pass = 0;

  hs_rx_buffer #(
    .DATA_W(8),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .level    (level),
    .proto_err(proto_err),
    .rx_count (rx_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ordy;
    logic [2:0] lvl;
    logic       ov;
    logic [7:0] od;
    logic       ir;
    logic       pe;
    int         pushes;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  function automatic vec_t mk(logic v, logic [7:0] d, logic ordy, logic [2:0] lvl, logic ov,
                              logic [7:0] od, logic ir, logic pe, int pushes);
    vec_t r;
    r.v = v; r.d = d; r.ordy = ordy; r.lvl = lvl; r.ov = ov;
    r.od = od; r.ir = ir; r.pe = pe; r.pushes = pushes;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q [$];
  logic [7:0] sd;

  initial begin
    // inputs, one edge, expected: lvl ov od ir pe pushes
    tbl[0]  = mk(1, 8'h11, 0, 3'd1, 1, 8'h11, 1, 0, 1);
    tbl[1]  = mk(1, 8'h22, 0, 3'd2, 1, 8'h11, 1, 0, 2);
    tbl[2]  = mk(1, 8'h33, 0, 3'd3, 1, 8'h11, 1, 0, 3);
    tbl[3]  = mk(1, 8'h44, 0, 3'd4, 1, 8'h11, 0, 0, 4);
    tbl[4]  = mk(1, 8'h55, 0, 3'd4, 1, 8'h11, 0, 0, 4);
    tbl[5]  = mk(1, 8'h55, 0, 3'd4, 1, 8'h11, 0, 0, 4);
    tbl[6]  = mk(1, 8'h55, 1, 3'd3, 1, 8'h22, 1, 0, 4);
    tbl[7]  = mk(1, 8'h55, 0, 3'd4, 1, 8'h22, 0, 0, 5);
    tbl[8]  = mk(0, 8'h00, 1, 3'd3, 1, 8'h33, 1, 0, 5);
    tbl[9]  = mk(0, 8'h00, 1, 3'd2, 1, 8'h44, 1, 0, 5);
    tbl[10] = mk(0, 8'h00, 1, 3'd1, 1, 8'h55, 1, 0, 5);
    tbl[11] = mk(0, 8'h00, 1, 3'd0, 0, 8'h00, 1, 0, 5);
    tbl[12] = mk(0, 8'h00, 1, 3'd0, 0, 8'h00, 1, 0, 5);
    tbl[13] = mk(1, 8'h66, 1, 3'd1, 1, 8'h66, 1, 0, 6);
    tbl[14] = mk(0, 8'h00, 0, 3'd1, 1, 8'h66, 1, 0, 6);
    tbl[15] = mk(0, 8'h00, 0, 3'd1, 1, 8'h66, 1, 0, 6);

    in_valid = 0; in_data = 0; out_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst level", 32'(level), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst proto_err", 32'(proto_err), 0);
    chk("rst rx_count", rx_count, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst in_ready held", 32'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("release in_ready pre-edge", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("release in_ready post-edge", 32'(in_ready), 1);

    for (int i = 0; i < NVEC; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].ordy);
      chk($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("vec%0d proto_err", i), 32'(proto_err), 32'(tbl[i].pe));
      chk($sformatf("vec%0d rx_count", i), rx_count, 32'(tbl[i].pushes * STATS));
    end

    // Streaming at level 2: simultaneous push/pop keeps level and order.
    cyc(1, 8'h77, 0);
    chk("stream pre level", 32'(level), 2);
    q.delete();
    q.push_back(8'h66);
    q.push_back(8'h77);
    for (int i = 0; i < 100; i++) begin
      sd = 8'h80 + 8'(i);
      chk($sformatf("stream%0d out_data", i), 32'(out_data), 32'(q[0]));
      cyc(1, sd, 1);
      void'(q.pop_front());
      q.push_back(sd);
      chk($sformatf("stream%0d level", i), 32'(level), 2);
    end
    cyc(0, 8'h00, 0);
    chk("stream post level", 32'(level), 2);
    chk("stream post out_data", 32'(out_data), 32'h E2);

    // Fill, stall an offer, withdraw it: sticky error, buffering continues.
    cyc(1, 8'hC1, 0);
    cyc(1, 8'hC2, 0);
    chk("full level", 32'(level), 4);
    chk("full in_ready", 32'(in_ready), 0);
    cyc(1, 8'hC3, 0);
    chk("stall proto_err", 32'(proto_err), 0);
    cyc(0, 8'h00, 0);
    chk("withdraw proto_err", 32'(proto_err), 1);
    chk("withdraw level", 32'(level), 4);
    cyc(0, 8'h00, 1);
    chk("err pop out_data", 32'(out_data), 32'h E3);
    cyc(1, 8'hD1, 1);
    chk("err pushpop level", 32'(level), 3);
    chk("err pushpop out_data", 32'(out_data), 32'h C1);
    chk("err sticky 1", 32'(proto_err), 1);
    cyc(0, 8'h00, 1);
    chk("err drain C2", 32'(out_data), 32'h C2);
    cyc(0, 8'h00, 1);
    chk("err drain D1", 32'(out_data), 32'h D1);
    cyc(0, 8'h00, 1);
    chk("err drain empty", 32'(out_valid), 0);
    chk("err sticky 2", 32'(proto_err), 1);

    // Reset mid-stream with level 3.
    cyc(1, 8'h31, 0);
    cyc(1, 8'h32, 0);
    cyc(1, 8'h33, 0);
    chk("pre-reset level", 32'(level), 3);
    in_valid = 1; in_data = 8'h34; out_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst level", 32'(level), 0);
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst in_ready", 32'(in_ready), 0);
    chk("midrst proto_err", 32'(proto_err), 0);
    chk("midrst rx_count", rx_count, 0);
    @(posedge clk);
    #1;
    chk("midrst level held", 32'(level), 0);
    in_valid = 0; out_ready = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst in_ready", 32'(in_ready), 1);
    chk("post-rst proto_err", 32'(proto_err), 0);

    // First push after reset is the first word out; then 9 more pushes for the counter.
    cyc(1, 8'hA5, 0);
    chk("post-rst first out_data", 32'(out_data), 32'h A5);
    chk("post-rst first level", 32'(level), 1);
    q.delete();
    q.push_back(8'hA5);
    for (int i = 0; i < 9; i++) begin
      sd = 8'h10 + 8'(i);
      chk($sformatf("cnt%0d out_data", i), 32'(out_data), 32'(q[0]));
      cyc(1, sd, 1);
      void'(q.pop_front());
      q.push_back(sd);
    end
    chk("cnt last out_data", 32'(out_data), 32'h 18);
    cyc(0, 8'h00, 1);
    chk("cnt drained", 32'(out_valid), 0);
    chk("cnt rx_count", rx_count, 32'(10 * STATS));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hs_rx_buffer.md
HS_RX_BUFFER -- requirements
Module: hs_rx_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width in bits, range 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries; must be a power of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-006 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-007 SHALL have port in_ready, output, 1 bit: buffer can accept a word this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds the oldest buffered word.
REQ-009 SHALL have port out_data, output, DATA_W bits: oldest buffered word (first-word fall-through).
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-012 SHALL have port proto_err, output, 1 bit: sticky upstream handshake violation.
REQ-013 SHALL have port rx_count, output, 32 bits: accepted-word counter (see Configuration).

Function
REQ-014 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1 (push).
REQ-015 SHALL release a word on a rising edge where out_valid=1 and out_ready=1 (pop).
REQ-016 SHALL drive in_ready = (level != DEPTH) from registered state only, with no combinational path from in_valid or out_ready.
REQ-017 SHALL drive out_valid = (level != 0), with out_data = entry at read pointer.
REQ-018 SHALL make a word pushed into an empty buffer visible on out_valid/out_data the cycle after the push (latency 1).
REQ-019 SHALL, on simultaneous push and pop with 0 < level < DEPTH, leave level unchanged and preserve FIFO order.
REQ-020 SHALL, when full, accept no push; a pop in that cycle raises in_ready the next cycle, not the same cycle.
REQ-021 SHALL, when empty, ignore out_ready.
REQ-022 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated words.
REQ-023 SHALL set proto_err when, in the previous cycle, in_valid=1 and in_ready=0, and this cycle in_valid=0 or in_data differs; proto_err stays 1 until reset.
REQ-024 SHALL continue normal buffering after proto_err is set.
REQ-025 SHALL keep out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-026 SHALL, while rst_n=0, force level=0, out_valid=0, in_ready=0, proto_err=0, rx_count=0, and both pointers to 0; out_data value is don't-care.
REQ-027 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-028 SHALL discard buffered contents on reset asserted mid-operation; no partial handshake completes in that cycle.

Configuration
REQ-029 SHALL compile the statistics counter only when macro HS_RX_BUFFER_STATS_EN is defined.
REQ-030 SHALL, with HS_RX_BUFFER_STATS_EN defined, increment rx_count by 1 per push, wrapping from 2^32-1 to 0.
REQ-031 SHALL, without HS_RX_BUFFER_STATS_EN, keep the rx_count port and tie it to constant 0, with no counter logic.

Structure
REQ-032 SHALL take DATA_W/DEPTH defaults, the 32-bit counter width constant and a level typedef helper from package hs_rx_pkg.
REQ-033 SHALL place the REQ-023 checker in one sub-module, hs_proto_chk (inputs clk, rst_n, valid, ready, data; output sticky err).

Verification
REQ-034 SHALL cover this scenario: DEPTH=4, push 0x11,0x22,0x33 with out_ready=0 -> level=3, out_data=0x11, in_ready=1.
REQ-035 SHALL cover this scenario: push 5 words with out_ready=0 -> 4 accepted, in_ready=0 while 0x55 is held, then one pop -> in_ready=1 next cycle and 0x55 accepted.
REQ-036 SHALL cover this scenario: in_valid and out_ready held at 1 for 100 cycles with level=2 -> level stays 2 and output sequence equals input order.
REQ-037 SHALL cover this scenario: with the buffer full, drop in_valid before acceptance -> proto_err=1 next cycle and stays 1 through later traffic.
REQ-038 SHALL cover this scenario: rst_n=0 mid-stream with level=3 -> level=0, out_valid=0 immediately; after release, the first push 0xA5 is the first word popped.
REQ-039 SHALL cover this scenario: with HS_RX_BUFFER_STATS_EN defined, 10 pushes -> rx_count=10; without the macro -> rx_count=0.
